// File: rtl/code_ram_arbiter_pkg.sv
// Shared types and constants for the code RAM arbiter: master identifiers
// and the default code RAM word-address width.
package code_ram_arbiter_pkg;

  localparam int CODE_RAM_ADDR_W = 12;

  typedef enum logic [1:0] {
    CR_MASTER_NONE  = 2'd0,
    CR_MASTER_INSTR = 2'd1,
    CR_MASTER_DATA  = 2'd2
  } code_ram_master_t;

  function automatic code_ram_master_t cr_other(input code_ram_master_t m);
    return (m == CR_MASTER_INSTR) ? CR_MASTER_DATA : CR_MASTER_INSTR;
  endfunction

endpackage

// File: rtl/code_ram_arbiter_if.sv
// Bundle of the two core bus ports and the code RAM macro port seen by the
// arbiter. The master modport is the environment (cores plus RAM macro).
interface code_ram_arbiter_if #(
  parameter int ADDR_W = code_ram_arbiter_pkg::CODE_RAM_ADDR_W
);
  // Handshake: a master raises xxx_req and holds it, with its address/write
  // fields stable, until the cycle xxx_gnt is high; that cycle is the
  // transfer. xxx_rvalid is high exactly one cycle later (reads and writes).
  logic              instr_req;
  logic              instr_gnt;
  logic [31:0]       instr_addr;
  logic              instr_rvalid;
  logic [31:0]       instr_rdata;

  logic              data_req;
  logic              data_gnt;
  logic [31:0]       data_addr;
  logic              data_we;
  logic [3:0]        data_be;
  logic [31:0]       data_wdata;
  logic              data_rvalid;
  logic [31:0]       data_rdata;

  logic              ram_req;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  modport master (
    output instr_req, instr_addr,
    output data_req, data_addr, data_we, data_be, data_wdata,
    output ram_rdata,
    input  instr_gnt, instr_rvalid, instr_rdata,
    input  data_gnt, data_rvalid, data_rdata,
    input  ram_req, ram_we, ram_be, ram_addr, ram_wdata
  );

  modport slave (
    input  instr_req, instr_addr,
    input  data_req, data_addr, data_we, data_be, data_wdata,
    input  ram_rdata,
    output instr_gnt, instr_rvalid, instr_rdata,
    output data_gnt, data_rvalid, data_rdata,
    output ram_req, ram_we, ram_be, ram_addr, ram_wdata
  );

endinterface

// File: rtl/code_ram_arbiter.sv
// Arbitrates the single-port code RAM between the instruction and data buses
// with bounded-streak round-robin and a registered responder tag.
module code_ram_arbiter
  import code_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = CODE_RAM_ADDR_W,
  parameter int MAX_BURST = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  code_ram_arbiter_if.slave              bus,
  output code_ram_master_t               dbg_last_master_o,
  output logic [$clog2(MAX_BURST+1)-1:0] dbg_streak_o,
  output code_ram_master_t               dbg_responding_o
);

  localparam int SW = $clog2(MAX_BURST + 1);
  localparam logic [SW-1:0] MAX_S = SW'(MAX_BURST);

  code_ram_master_t last_master_q, last_master_d;
  logic [SW-1:0]    streak_q, streak_d;
  code_ram_master_t responding_q, responding_d;
  code_ram_master_t winner;

  // Byte-offset and out-of-range address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.instr_addr[31:ADDR_W+2], bus.instr_addr[1:0],
                              bus.data_addr[31:ADDR_W+2], bus.data_addr[1:0]};

  always_comb begin
    winner        = CR_MASTER_NONE;
    last_master_d = last_master_q;
    streak_d      = streak_q;
    bus.instr_gnt = 1'b0;
    bus.data_gnt  = 1'b0;
    bus.ram_req   = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_be    = 4'h0;
    bus.ram_addr  = '0;
    bus.ram_wdata = 32'h0;

    if (!rst) begin
      unique case ({bus.instr_req, bus.data_req})
        2'b10:   winner = CR_MASTER_INSTR;
        2'b01:   winner = CR_MASTER_DATA;
        // streak == 0 only after reset: the non-last master (INSTR) goes first.
        2'b11:   winner = (streak_q != '0 && streak_q != MAX_S) ? last_master_q
                                                                : cr_other(last_master_q);
        default: winner = CR_MASTER_NONE;
      endcase
    end

    if (winner == CR_MASTER_INSTR) begin
      bus.instr_gnt = 1'b1;
      bus.ram_req   = 1'b1;
      bus.ram_be    = 4'hF;
      bus.ram_addr  = bus.instr_addr[ADDR_W+1:2];
    end else if (winner == CR_MASTER_DATA) begin
      bus.data_gnt  = 1'b1;
      bus.ram_req   = 1'b1;
      bus.ram_we    = bus.data_we;
      bus.ram_be    = bus.data_be;
      bus.ram_addr  = bus.data_addr[ADDR_W+1:2];
      bus.ram_wdata = bus.data_wdata;
    end

    if (winner != CR_MASTER_NONE) begin
      if (winner == last_master_q) begin
        streak_d = (streak_q == MAX_S) ? MAX_S : streak_q + SW'(1);
      end else begin
        last_master_d = winner;
        streak_d      = SW'(1);
      end
    end
    responding_d = winner;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_master_q <= CR_MASTER_DATA;
      streak_q      <= '0;
      responding_q  <= CR_MASTER_NONE;
    end else begin
      last_master_q <= last_master_d;
      streak_q      <= streak_d;
      responding_q  <= responding_d;
    end
  end

  // A response owed from the cycle before reset is discarded.
  assign bus.instr_rvalid = !rst && (responding_q == CR_MASTER_INSTR);
  assign bus.data_rvalid  = !rst && (responding_q == CR_MASTER_DATA);
  assign bus.instr_rdata  = bus.ram_rdata;
  assign bus.data_rdata   = bus.ram_rdata;

  assign dbg_last_master_o = last_master_q;
  assign dbg_streak_o      = streak_q;
  assign dbg_responding_o  = responding_q;

endmodule

// File: tb/tb_code_ram_arbiter.sv
// Directed bench for code_ram_arbiter: two instances (MAX_BURST 4 and 1),
// each with a one-cycle-latency RAM model returning 0xC0DE0000 | word address.
module tb_code_ram_arbiter;
  import code_ram_arbiter_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  code_ram_arbiter_if #(.ADDR_W(CODE_RAM_ADDR_W)) if4 ();
  code_ram_arbiter_if #(.ADDR_W(CODE_RAM_ADDR_W)) if1 ();

  code_ram_master_t dbg_last4, dbg_resp4, dbg_last1, dbg_resp1;
  logic [2:0]       dbg_streak4;
  logic [0:0]       dbg_streak1;

  code_ram_arbiter #(.ADDR_W(CODE_RAM_ADDR_W), .MAX_BURST(4)) u_dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave),
    .dbg_last_master_o(dbg_last4), .dbg_streak_o(dbg_streak4), .dbg_responding_o(dbg_resp4)
  );

  code_ram_arbiter #(.ADDR_W(CODE_RAM_ADDR_W), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave),
    .dbg_last_master_o(dbg_last1), .dbg_streak_o(dbg_streak1), .dbg_responding_o(dbg_resp1)
  );

  always @(posedge clk) begin
    if4.ram_rdata <= 32'hC0DE_0000 | 32'(if4.ram_addr);
    if1.ram_rdata <= 32'hC0DE_0000 | 32'(if1.ram_addr);
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  // driver tasks
  task automatic drive_idle();
    if4.instr_req = 1'b0; if4.instr_addr = 32'h0;
    if4.data_req = 1'b0; if4.data_addr = 32'h0; if4.data_we = 1'b0;
    if4.data_be = 4'h0; if4.data_wdata = 32'h0;
    if1.instr_req = 1'b0; if1.instr_addr = 32'h0;
    if1.data_req = 1'b0; if1.data_addr = 32'h0; if1.data_we = 1'b0;
    if1.data_be = 4'h0; if1.data_wdata = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    if4.instr_req = 1'b1; if4.data_req = 1'b1;
    if1.instr_req = 1'b1; if1.data_req = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({if4.instr_gnt, if4.data_gnt, if4.ram_req, if4.instr_rvalid, if4.data_rvalid} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs4 cycle %0d: got %b want 00000", c,
                 {if4.instr_gnt, if4.data_gnt, if4.ram_req, if4.instr_rvalid, if4.data_rvalid});
      end
      n_checks++;
      if ({if1.instr_gnt, if1.data_gnt, if1.ram_req, if1.instr_rvalid, if1.data_rvalid} !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_outputs1 cycle %0d: got %b want 00000", c,
                 {if1.instr_gnt, if1.data_gnt, if1.ram_req, if1.instr_rvalid, if1.data_rvalid});
      end
      n_checks++;
      if (dbg_streak4 !== 3'd0 || dbg_last4 !== CR_MASTER_DATA || dbg_resp4 !== CR_MASTER_NONE) begin
        n_fail++;
        $display("FAIL reset_state4: got streak %0d last %0d resp %0d want 0 2 0",
                 dbg_streak4, dbg_last4, dbg_resp4);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({if4.instr_gnt, if4.data_gnt, if4.instr_rvalid, if4.data_rvalid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_first_contended: got %b want 1000",
               {if4.instr_gnt, if4.data_gnt, if4.instr_rvalid, if4.data_rvalid});
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if ({if4.instr_rvalid, if4.data_rvalid} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_rvalid: got %b want 10", {if4.instr_rvalid, if4.data_rvalid});
    end
  endtask

  task automatic test_single_read();
    do_reset();
    @(negedge clk);
    if4.instr_req = 1'b1; if4.instr_addr = 32'h0000_0104;
    #1;
    n_checks++;
    if ({if4.instr_gnt, if4.data_gnt, if4.ram_req, if4.ram_we} !== 4'b1010) begin
      n_fail++;
      $display("FAIL read_gnt: got %b want 1010", {if4.instr_gnt, if4.data_gnt, if4.ram_req, if4.ram_we});
    end
    n_checks++;
    if (if4.ram_addr !== 12'h041 || if4.ram_be !== 4'hF) begin
      n_fail++;
      $display("FAIL read_ram_fields: got addr %h be %h want 041 f", if4.ram_addr, if4.ram_be);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if ({if4.instr_rvalid, if4.data_rvalid} !== 2'b10 || if4.instr_rdata !== 32'hC0DE_0041) begin
      n_fail++;
      $display("FAIL read_response: got rvalid %b rdata %h want 10 c0de0041",
               {if4.instr_rvalid, if4.data_rvalid}, if4.instr_rdata);
    end
    n_checks++;
    if ({if4.ram_req, if4.ram_we, if4.ram_be} !== 6'b0 || if4.ram_addr !== 12'h0 || if4.ram_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL idle_ram_outputs: got req %b we %b be %h addr %h wdata %h want all zero",
               if4.ram_req, if4.ram_we, if4.ram_be, if4.ram_addr, if4.ram_wdata);
    end
  endtask

  task automatic test_write();
    @(negedge clk);
    if4.data_req = 1'b1; if4.data_we = 1'b1; if4.data_be = 4'b0011;
    if4.data_wdata = 32'hDEAD_BEEF; if4.data_addr = 32'h0000_0008;
    #1;
    n_checks++;
    if ({if4.instr_gnt, if4.data_gnt, if4.ram_req, if4.ram_we} !== 4'b0111) begin
      n_fail++;
      $display("FAIL write_gnt: got %b want 0111", {if4.instr_gnt, if4.data_gnt, if4.ram_req, if4.ram_we});
    end
    n_checks++;
    if (if4.ram_be !== 4'b0011 || if4.ram_addr !== 12'h002 || if4.ram_wdata !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL write_ram_fields: got be %b addr %h wdata %h want 0011 002 deadbeef",
               if4.ram_be, if4.ram_addr, if4.ram_wdata);
    end
    @(negedge clk);
    drive_idle();
    #1;
    n_checks++;
    if ({if4.instr_rvalid, if4.data_rvalid} !== 2'b01) begin
      n_fail++;
      $display("FAIL write_rvalid: got %b want 01", {if4.instr_rvalid, if4.data_rvalid});
    end
  endtask

  task automatic test_contention_burst4();
    logic [1:0] exp_gnt, exp_rv;
    logic [11:0] exp_addr;
    do_reset();
    exp_q.delete();
    exp_q.push_back(2'b00);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if4.instr_req = 1'b1; if4.instr_addr = 32'h0000_0100;
      if4.data_req = 1'b1; if4.data_addr = 32'h0000_0200;
      #1;
      exp_gnt  = (((i / 4) % 2) == 1) ? 2'b01 : 2'b10;
      exp_addr = (exp_gnt == 2'b10) ? 12'h040 : 12'h080;
      n_checks++;
      if ({if4.instr_gnt, if4.data_gnt} !== exp_gnt || if4.ram_addr !== exp_addr) begin
        n_fail++;
        $display("FAIL burst4_gnt cycle %0d: got gnt %b addr %h want %b %h",
                 i, {if4.instr_gnt, if4.data_gnt}, if4.ram_addr, exp_gnt, exp_addr);
      end
      exp_rv = exp_q.pop_front();
      n_checks++;
      if ({if4.instr_rvalid, if4.data_rvalid} !== exp_rv) begin
        n_fail++;
        $display("FAIL burst4_rvalid cycle %0d: got %b want %b", i, {if4.instr_rvalid, if4.data_rvalid}, exp_rv);
      end
      exp_q.push_back(exp_gnt);
    end
    @(negedge clk);
    drive_idle();
    #1;
    exp_rv = exp_q.pop_front();
    n_checks++;
    if ({if4.instr_rvalid, if4.data_rvalid} !== exp_rv || if4.data_rdata !== 32'hC0DE_0080) begin
      n_fail++;
      $display("FAIL burst4_last_response: got rvalid %b rdata %h want %b c0de0080",
               {if4.instr_rvalid, if4.data_rvalid}, if4.data_rdata, exp_rv);
    end
  endtask

  task automatic test_contention_burst1();
    logic [1:0] exp_gnt, exp_rv;
    do_reset();
    exp_q.delete();
    exp_q.push_back(2'b00);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      // cycle 6 is the idle gap; the alternation resumes after it
      if1.instr_req = (i != 6); if1.data_req = (i != 6);
      #1;
      exp_gnt = (i == 6) ? 2'b00 : (((i < 6 ? i : i - 1) % 2) == 1) ? 2'b01 : 2'b10;
      n_checks++;
      if ({if1.instr_gnt, if1.data_gnt} !== exp_gnt) begin
        n_fail++;
        $display("FAIL burst1_gnt cycle %0d: got %b want %b", i, {if1.instr_gnt, if1.data_gnt}, exp_gnt);
      end
      exp_rv = exp_q.pop_front();
      n_checks++;
      if ({if1.instr_rvalid, if1.data_rvalid} !== exp_rv) begin
        n_fail++;
        $display("FAIL burst1_rvalid cycle %0d: got %b want %b", i, {if1.instr_rvalid, if1.data_rvalid}, exp_rv);
      end
      exp_q.push_back(exp_gnt);
      if (i == 6) begin
        n_checks++;
        if (dbg_last1 !== CR_MASTER_DATA || dbg_streak1 !== 1'b1) begin
          n_fail++;
          $display("FAIL burst1_idle_hold: got last %0d streak %0d want 2 1", dbg_last1, dbg_streak1);
        end
      end
    end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if4.data_req = 1'b1; if4.data_addr = 32'h0000_0010;
      #1;
      n_checks++;
      if ({if4.instr_gnt, if4.data_gnt} !== 2'b01) begin
        n_fail++;
        $display("FAIL midrst_data_gnt %0d: got %b want 01", i, {if4.instr_gnt, if4.data_gnt});
      end
    end
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    #1;
    n_checks++;
    if ({if4.instr_rvalid, if4.data_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_rvalid_during_rst: got %b want 00", {if4.instr_rvalid, if4.data_rvalid});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({if4.instr_rvalid, if4.data_rvalid} !== 2'b00 || dbg_streak4 !== 3'd0 || dbg_last4 !== CR_MASTER_DATA) begin
      n_fail++;
      $display("FAIL midrst_after_release: got rvalid %b streak %0d last %0d want 00 0 2",
               {if4.instr_rvalid, if4.data_rvalid}, dbg_streak4, dbg_last4);
    end
    @(negedge clk);
    if4.instr_req = 1'b1; if4.data_req = 1'b1;
    #1;
    n_checks++;
    if ({if4.instr_gnt, if4.data_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL midrst_next_contended: got %b want 10", {if4.instr_gnt, if4.data_gnt});
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_contention_burst4();
    test_contention_burst1();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
